// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: next-PC sequencer in front of the PC register.
// Arbitrates trap > EX branch > ID jump > PC+4. It drives new_pc, pc_hold and the
// IF/ID and ID/EX flushes. A single redirect is held while a cache stall is active.
// Fetch is held for a fixed window after reset is released.
module pc_redirect_ctrl #(
  parameter int                    DATA_WID    = 32,
  parameter logic [DATA_WID-1:0]   RESET_VEC   = '0,
  parameter int                    BOOT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_WID-1:0] pc_cur,
  input  logic                hazard_stall,
  input  logic                icache_stall,
  input  logic                dcache_stall,
  input  logic                trap_req,
  input  logic [DATA_WID-1:0] trap_target,
  input  logic                br_taken,
  input  logic [DATA_WID-1:0] br_target,
  input  logic                jal_valid,
  input  logic [DATA_WID-1:0] jal_target,
  output logic [DATA_WID-1:0] new_pc,
  output logic                pc_hold,
  output logic                flush_if_id,
  output logic                flush_id_ex,
  output logic                redirect_pending
);

  localparam int CNT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOOT_CYCLES - 1);

  localparam logic [1:0] PRIO_JAL  = 2'd0;
  localparam logic [1:0] PRIO_BR   = 2'd1;
  localparam logic [1:0] PRIO_TRAP = 2'd2;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_boot_cnt;
  logic                r_pend_valid;
  logic [1:0]          r_pend_prio;
  logic [DATA_WID-1:0] r_pend_target;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_boot_cnt_nxt;
  logic                w_pend_valid_nxt;
  logic [1:0]          w_pend_prio_nxt;
  logic [DATA_WID-1:0] w_pend_target_nxt;

  logic                w_cstall;
  logic                w_req_any;
  logic [1:0]          w_req_prio;
  logic [DATA_WID-1:0] w_req_target;
  logic [DATA_WID-1:0] w_seq_pc;
  logic                w_req_wins;
  logic [1:0]          w_eff_prio;
  logic [DATA_WID-1:0] w_eff_target;

  // Word-align an address: the low two bits of every emitted PC are forced to zero.
  function automatic logic [DATA_WID-1:0] align_pc(input logic [DATA_WID-1:0] addr);
    return {addr[DATA_WID-1:2], 2'b00};
  endfunction

  // Select the highest-priority redirect request of this cycle.
  always_comb begin
    w_cstall     = icache_stall | dcache_stall;
    w_req_any    = trap_req | br_taken | jal_valid;
    w_seq_pc     = align_pc(pc_cur + DATA_WID'(4));
    w_req_prio   = PRIO_JAL;
    w_req_target = align_pc(jal_target);
    if (trap_req) begin
      w_req_prio   = PRIO_TRAP;
      w_req_target = align_pc(trap_target);
    end else if (br_taken) begin
      w_req_prio   = PRIO_BR;
      w_req_target = align_pc(br_target);
    end else begin
      w_req_prio   = PRIO_JAL;
      w_req_target = align_pc(jal_target);
    end
    // While pending, only a strictly older (higher-priority) request displaces the entry.
    w_req_wins = w_req_any && (w_req_prio > r_pend_prio);
    if (w_req_wins) begin
      w_eff_prio   = w_req_prio;
      w_eff_target = w_req_target;
    end else begin
      w_eff_prio   = r_pend_prio;
      w_eff_target = r_pend_target;
    end
  end

  // Next-state, pending-entry update and all PC-control outputs.
  always_comb begin
    new_pc            = RESET_VEC;
    pc_hold           = 1'b1;
    flush_if_id       = 1'b1;
    flush_id_ex       = 1'b1;
    redirect_pending  = 1'b0;
    w_state_nxt       = r_state;
    w_boot_cnt_nxt    = r_boot_cnt;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_prio_nxt   = r_pend_prio;
    w_pend_target_nxt = r_pend_target;
    if (!rst) begin
      // Reset values above are presented while reset is asserted.
      w_state_nxt = S_BOOT;
    end else begin
      case (r_state)
        S_BOOT: begin
          // Boot window: reset outputs, redirect inputs ignored.
          if (r_boot_cnt == CNT_LAST) begin
            w_state_nxt    = S_RUN;
            w_boot_cnt_nxt = r_boot_cnt;
          end else begin
            w_state_nxt    = S_BOOT;
            w_boot_cnt_nxt = r_boot_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          flush_if_id = 1'b0;
          flush_id_ex = 1'b0;
          if (w_req_any) begin
            new_pc = w_req_target;
            if (w_cstall) begin
              pc_hold           = 1'b1;
              w_pend_valid_nxt  = 1'b1;
              w_pend_prio_nxt   = w_req_prio;
              w_pend_target_nxt = w_req_target;
              w_state_nxt       = S_PEND;
            end else begin
              // A redirect beats a load-use stall: the stalled instruction is squashed.
              pc_hold     = 1'b0;
              flush_if_id = 1'b1;
              flush_id_ex = (w_req_prio != PRIO_JAL);
            end
          end else begin
            new_pc  = w_seq_pc;
            pc_hold = hazard_stall | w_cstall;
          end
        end
        S_PEND: begin
          flush_if_id = 1'b0;
          flush_id_ex = 1'b0;
          if (w_cstall) begin
            new_pc            = r_pend_target;
            pc_hold           = 1'b1;
            redirect_pending  = 1'b1;
            w_pend_prio_nxt   = w_eff_prio;
            w_pend_target_nxt = w_eff_target;
          end else begin
            new_pc            = w_eff_target;
            pc_hold           = 1'b0;
            flush_if_id       = 1'b1;
            flush_id_ex       = (w_eff_prio != PRIO_JAL);
            w_pend_valid_nxt  = 1'b0;
            w_pend_prio_nxt   = PRIO_JAL;
            w_pend_target_nxt = '0;
            w_state_nxt       = S_RUN;
          end
        end
        default: begin
          w_state_nxt = S_BOOT;
        end
      endcase
    end
  end

  // State, boot counter and pending entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_BOOT;
      r_boot_cnt    <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_prio   <= PRIO_JAL;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_boot_cnt    <= w_boot_cnt_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_prio   <= w_pend_prio_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end

endmodule
